// File: rtl/imm_encoder_if.sv
// imm_encoder_if
//   Streaming bus for the immediate encoder.
//   Input channel : in_valid/in_ready plus imm_src, imm and base_instr.
//   Output channel: out_valid/out_ready plus instr, range_err and align_err.
//   master modport: the producer/consumer side (test-program generator or bench).
//   slave modport : the encoder itself.
interface imm_encoder_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            imm_src;
  logic [DATA_WIDTH-1:0] imm;
  logic [31:0]           base_instr;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           instr;
  logic                  range_err;
  logic                  align_err;

  modport master (
    output in_valid, imm_src, imm, base_instr, out_ready,
    input  in_ready, out_valid, instr, range_err, align_err
  );

  modport slave (
    input  in_valid, imm_src, imm, base_instr, out_ready,
    output in_ready, out_valid, instr, range_err, align_err
  );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder
//   Packs a two's-complement immediate into the RV32I bit positions of the
//   selected format (I/S/B/U/J) on top of a base instruction word, flagging
//   immediates that do not fit or whose low bits cannot be encoded.
//   Two-stage valid/ready pipeline with full throughput and registered outputs.
// Ports
//   clk       : rising-edge clock
//   rst_n     : synchronous reset, active-low
//   bus       : imm_encoder_if slave (input and output handshake channels)
//   enc_count : number of outputs handed off, wraps
//   err_count : number of handed-off outputs with any error, saturates
// Only DATA_WIDTH = 32 is supported; field positions are fixed RV32I bits.
module imm_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imm_encoder_if.slave         bus,
  output logic [CNT_WIDTH-1:0] enc_count,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_U = 3'b011;
  localparam logic [2:0] SRC_J = 3'b100;

  logic                  s1_valid;
  logic [2:0]            s1_src;
  logic [DATA_WIDTH-1:0] s1_imm;
  logic [31:0]           s1_base;

  logic                  out_valid_q;
  logic [31:0]           instr_q;
  logic                  range_q;
  logic                  align_q;

  logic                  adv2;
  logic                  in_ready_c;
  logic [31:0]           packed_word;
  logic                  range_c;
  logic                  align_c;

  // Stage 2 may load whenever its slot is empty or being drained this cycle;
  // stage 1 may accept whenever it is empty or can pass its item forward.
  assign adv2       = !out_valid_q || bus.out_ready;
  assign in_ready_c = !s1_valid || adv2;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.instr     = instr_q;
  assign bus.range_err = range_q;
  assign bus.align_err = align_q;

  // Packing and error detection from the stage-1 registers. The base word
  // passes through except where the format's immediate field lives. A field
  // "fits" when every bit above the encodable sign bit matches it, i.e. the
  // slice is all zeros or all ones. Codes 101-111 fall into the I default.
  always_comb begin
    packed_word = s1_base;
    range_c     = 1'b0;
    align_c     = 1'b0;
    case (s1_src)
      SRC_S: begin
        packed_word[31:25] = s1_imm[11:5];
        packed_word[11:7]  = s1_imm[4:0];
        range_c            = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
      end
      SRC_B: begin
        packed_word[31]    = s1_imm[12];
        packed_word[30:25] = s1_imm[10:5];
        packed_word[11:8]  = s1_imm[4:1];
        packed_word[7]     = s1_imm[11];
        range_c            = !((&s1_imm[31:12]) || !(|s1_imm[31:12]));
        align_c            = s1_imm[0];
      end
      SRC_U: begin
        packed_word[31:12] = s1_imm[31:12];
        align_c            = |s1_imm[11:0];
      end
      SRC_J: begin
        packed_word[31]    = s1_imm[20];
        packed_word[30:21] = s1_imm[10:1];
        packed_word[20]    = s1_imm[11];
        packed_word[19:12] = s1_imm[19:12];
        range_c            = !((&s1_imm[31:20]) || !(|s1_imm[31:20]));
        align_c            = s1_imm[0];
      end
      default: begin
        packed_word[31:20] = s1_imm[11:0];
        range_c            = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
      end
    endcase
  end

  // Stage 1 captures the raw request. Its valid bit is rewritten every cycle
  // the stage is allowed to accept, so a drained item is not duplicated.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_src   <= '0;
      s1_imm   <= '0;
      s1_base  <= '0;
    end else if (in_ready_c) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_src  <= bus.imm_src;
        s1_imm  <= bus.imm;
        s1_base <= bus.base_instr;
      end
    end
  end

  // Stage 2 registers the packed word and flags. Data only loads with a real
  // item so outputs stay frozen while a stalled result waits downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      range_q     <= 1'b0;
      align_q     <= 1'b0;
    end else if (adv2) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        instr_q <= packed_word;
        range_q <= range_c;
        align_q <= align_c;
      end
    end
  end

  // Statistics advance only on an output handoff. The error counter sticks
  // at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (out_valid_q && bus.out_ready) begin
      enc_count <= enc_count + 1'b1;
      if ((range_q || align_q) && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder
//   Directed-vector bench for imm_encoder: reset state, every format including
//   boundary and error cases, a round-trip sweep through an independent
//   immediate decoder, backpressure streaming and reset with items in flight.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;
  int expEnc = 0;
  int expErr = 0;

  imm_encoder_if #(.DATA_WIDTH(32)) bus ();

  imm_encoder #(
    .DATA_WIDTH(32),
    .CNT_WIDTH (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .enc_count(enc_count),
    .err_count(err_count)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // Hard stop in case some wait escapes its own bound
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [2:0]  src;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] expInstr;
    logic        expRange;
    logic        expAlign;
  } vec_t;

  // Hand-computed vectors
  vec_t vecs [13] = '{
    '{3'd0, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0, 1'b0},
    '{3'd0, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1, 1'b0},
    '{3'd0, 32'h0000_0000, 32'hFFF0_0013, 32'h0000_0013, 1'b0, 1'b0},
    '{3'd5, 32'h0000_07FF, 32'h0000_0013, 32'h7FF0_0013, 1'b0, 1'b0},
    '{3'd1, 32'hFFFF_FFFF, 32'h0000_2023, 32'hFE00_2FA3, 1'b0, 1'b0},
    '{3'd2, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0, 1'b0},
    '{3'd2, 32'h0000_1000, 32'h0000_0063, 32'h8000_0063, 1'b1, 1'b0},
    '{3'd2, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b0, 1'b1},
    '{3'd3, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0, 1'b0},
    '{3'd3, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 1'b0, 1'b1},
    '{3'd4, 32'hFFF0_0000, 32'h0000_006F, 32'h8000_006F, 1'b0, 1'b0},
    '{3'd4, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 1'b1, 1'b0},
    '{3'd4, 32'h0000_07FE, 32'h0000_00EF, 32'h7FE0_00EF, 1'b0, 1'b0}
  };

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Independent RV32I sign-extension decoder
  function automatic logic [31:0] decodeImm(input logic [2:0] src, input logic [31:0] w);
    case (src)
      3'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3:    return {w[31:12], 12'b0};
      3'd4:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return {{20{w[31]}}, w[31:20]};
    endcase
  endfunction

  task automatic doReset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    expEnc = 0;
    expErr = 0;
  endtask

  // Send one item with the output side always ready and collect its result.
  task automatic applyStimulus(input string tag, input logic [2:0] src, input logic [31:0] iv,
                               input logic [31:0] base, output logic [31:0] oInstr,
                               output logic oRange, output logic oAlign);
    int waitc;
    int edges;
    @(negedge clk);
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.imm_src    = src;
    bus.imm        = iv;
    bus.base_instr = base;
    waitc = 0;
    while (!bus.in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.in_ready) checkOutput({tag, "_inready"}, {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    edges = 1;
    while (!bus.out_valid && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    checkOutput({tag, "_lat"}, edges, 32'd2);
    oInstr = bus.instr;
    oRange = bus.range_err;
    oAlign = bus.align_err;
  endtask

  initial begin
    logic [31:0] gotInstr;
    logic        gotRange;
    logic        gotAlign;
    logic [31:0] v;
    logic [31:0] iv;
    logic [31:0] base;

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.imm_src    = '0;
    bus.imm        = '0;
    bus.base_instr = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    checkOutput("rst_instr",     bus.instr,              32'd0);
    checkOutput("rst_flags",     {30'b0, bus.range_err, bus.align_err}, 32'd0);
    checkOutput("rst_enc",       {16'b0, enc_count},     32'd0);
    checkOutput("rst_err",       {16'b0, err_count},     32'd0);

    // Directed vectors, counters checked after each handoff edge
    for (int i = 0; i < 13; i++) begin
      applyStimulus($sformatf("v%0d", i), vecs[i].src, vecs[i].imm, vecs[i].base,
                    gotInstr, gotRange, gotAlign);
      checkOutput($sformatf("v%0d_instr", i), gotInstr, vecs[i].expInstr);
      checkOutput($sformatf("v%0d_range", i), {31'b0, gotRange}, {31'b0, vecs[i].expRange});
      checkOutput($sformatf("v%0d_align", i), {31'b0, gotAlign}, {31'b0, vecs[i].expAlign});
      expEnc++;
      if (vecs[i].expRange || vecs[i].expAlign) expErr++;
      @(negedge clk);
      checkOutput($sformatf("v%0d_enc", i), {16'b0, enc_count}, 32'(expEnc));
      checkOutput($sformatf("v%0d_err", i), {16'b0, err_count}, 32'(expErr));
    end

    // Round-trip sweep: in-range aligned values for each format
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 4; k++) begin
        v    = $urandom;
        base = $urandom;
        case (f)
          1:       iv = {{20{v[11]}}, v[11:0]};
          2:       iv = {{19{v[12]}}, v[12:1], 1'b0};
          3:       iv = {v[31:12], 12'b0};
          4:       iv = {{11{v[20]}}, v[20:1], 1'b0};
          default: iv = {{20{v[11]}}, v[11:0]};
        endcase
        applyStimulus($sformatf("rt%0d_%0d", f, k), 3'(f), iv, base, gotInstr, gotRange, gotAlign);
        checkOutput($sformatf("rt%0d_%0d_imm", f, k), decodeImm(3'(f), gotInstr), iv);
        checkOutput($sformatf("rt%0d_%0d_op", f, k), {25'b0, gotInstr[6:0]}, {25'b0, base[6:0]});
        checkOutput($sformatf("rt%0d_%0d_flags", f, k), {30'b0, gotRange, gotAlign}, 32'd0);
      end
    end

    // Reset with two items in flight and the output stalled
    @(negedge clk);
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.imm_src    = 3'd0;
    bus.imm        = 32'h0000_0011;
    bus.base_instr = 32'h0000_0013;
    @(posedge clk);
    @(negedge clk);
    bus.imm = 32'h0000_0022;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("mid_pre_valid", {31'b0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mid_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("mid_in_ready",  {31'b0, bus.in_ready},  32'd1);
    checkOutput("mid_enc",       {16'b0, enc_count},     32'd0);
    checkOutput("mid_err",       {16'b0, err_count},     32'd0);
    bus.out_ready = 1'b1;
    begin
      int stale = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (bus.out_valid) stale++;
      end
      checkOutput("mid_stale", stale, 32'd0);
    end

    // Backpressure stream: 8 items, out_ready toggling 1010...
    doReset();
    fork
      begin
        int idx = 0;
        int cyc = 0;
        logic acc;
        while (idx < 8 && cyc < 200) begin
          @(negedge clk);
          bus.in_valid   = 1'b1;
          bus.imm_src    = 3'd0;
          bus.imm        = 32'(idx + 1);
          bus.base_instr = 32'h0000_0013;
          #1;
          acc = bus.in_ready;
          @(posedge clk);
          if (acc) idx++;
          cyc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      begin
        int got = 0;
        int cyc = 0;
        logic tog = 1'b1;
        while (got < 8 && cyc < 200) begin
          @(negedge clk);
          bus.out_ready = tog;
          tog = ~tog;
          #1;
          if (bus.out_valid && bus.out_ready) begin
            checkOutput($sformatf("bp%0d", got), bus.instr, (32'(got + 1) << 20) | 32'h13);
            got++;
          end
          cyc++;
        end
        checkOutput("bp_count", got, 32'd8);
      end
    join
    @(negedge clk);
    bus.out_ready = 1'b1;
    checkOutput("bp_enc", {16'b0, enc_count}, 32'd8);
    checkOutput("bp_err", {16'b0, err_count}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_drained", {31'b0, bus.out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
